nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that reuses one 4-bit combinational adder slice, processing one nibble per clock from LSB to MSB.
- Sits around the 4-bit ripple slice: feeds it operand nibbles plus the registered carry, and consumes its Sum/Cout.
- Gives wide additions at the area cost of a single 4-bit slice.
- Start/busy/done handshake toward the requesting datapath.

---
 rtl/nibble_serial_adder_pkg.sv | 19 +
 rtl/nibble_add4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding, slice
// width and the operand-width legality check.
package nibble_serial_adder_pkg;

  localparam int SLICE_W   = 4;
  localparam int MIN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width must split into whole nibbles and give at least two of them
  function automatic bit width_is_legal(input int width);
    return ((width % SLICE_W) == 0) && (width >= MIN_WIDTH);
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice shared by every nibble step.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic carry;

  // Ripple the carry bit by bit through the nibble
  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that walks one nibble per clock from LSB to
// MSB through a single shared 4-bit slice, with a start/busy/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Refuse to elaborate for widths that do not split into at least two nibbles
  generate
    if (!width_is_legal(WIDTH)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t              state;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    acc_r;
  logic                carry_r;
  logic [CNT_W-1:0]    cnt;
  logic                a_msb;
  logic                b_msb;

  logic [SLICE_W-1:0]  slice_s;
  logic                slice_co;
  logic [WIDTH-1:0]    acc_next;
  logic                ovf_next;

  nibble_add4 u_slice (
    .a  (a_r[SLICE_W-1:0]),
    .b  (b_r[SLICE_W-1:0]),
    .ci (carry_r),
    .s  (slice_s),
    .co (slice_co)
  );

  // New result nibble enters at the top so the final nibble lands the
  // accumulator in natural bit order
  assign acc_next = {slice_s, acc_r[WIDTH-1:SLICE_W]};
  assign ovf_next = (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);

  // Handshake FSM plus operand shifting and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      carry_r  <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= Cin;
            a_msb   <= A[WIDTH-1];
            b_msb   <= B[WIDTH-1];
            acc_r   <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          acc_r   <= acc_next;
          carry_r <= slice_co;
          a_r     <= {{SLICE_W{1'b0}}, a_r[WIDTH-1:SLICE_W]};
          b_r     <= {{SLICE_W{1'b0}}, b_r[WIDTH-1:SLICE_W]};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum      <= acc_next;
            Cout     <= slice_co;
            Overflow <= ovf_next;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16: expected results are
// queued when a start is driven and checked when done pulses.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // One comparison: count it, and count and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive start for one edge from a negedge; queue the reference result if
  // the DUT is expected to accept it, then scramble the don't-care inputs
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic ci, input bit accepted);
    exp_t           e;
    logic [WIDTH:0] total;
    A     = a;
    B     = b;
    Cin   = ci;
    start = 1'b1;
    if (accepted) begin
      total  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      e.sum  = total[WIDTH-1:0];
      e.cout = total[WIDTH];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A     = WIDTH'($urandom);
    B     = WIDTH'($urandom);
    Cin   = 1'($urandom);
  endtask

  // Wait (bounded) for done, check latency and busy span, then score the result
  task automatic waitResult(input string tag, input int exp_lat);
    int   cycles      = 0;
    int   busy_cycles = 0;
    exp_t e;
    while (!done && cycles < 4 * N) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    if (done) begin
      checkOutput({tag, "_queue_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({tag, "_sum"},  32'(Sum),      32'(e.sum));
        checkOutput({tag, "_cout"}, 32'(Cout),     32'(e.cout));
        checkOutput({tag, "_ovf"},  32'(Overflow), 32'(e.ovf));
      end
    end
  endtask

  // Directed sequence
  initial begin
    int extra;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum",  32'(Sum),  32'd0);
    checkOutput("reset_cout", 32'(Cout), 32'd0);
    checkOutput("reset_ovf",  32'(Overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic add 0x1234+0x4321");
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1);
    waitResult("t1", N);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", 32'(done), 32'd0);
    checkOutput("t1_sum_held", 32'(Sum), 32'h5555);

    $display("[TB] full carry ripple 0xFFFF+0x0001");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    waitResult("t2", N);
    @(negedge clk);

    $display("[TB] signed overflow 0x7FFF+0x0000+1");
    applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b1);
    waitResult("t3", N);
    @(negedge clk);

    $display("[TB] start during RUN is ignored");
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    waitResult("t4", N - 2);
    extra = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("t4_single_done", 32'(extra), 32'd0);
    checkOutput("t4_sum_held", 32'(Sum), 32'h0002);

    $display("[TB] reset in RUN cycle 3");
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_sum",  32'(Sum),  32'd0);
    checkOutput("t5_cout", 32'(Cout), 32'd0);
    checkOutput("t5_ovf",  32'(Overflow), 32'd0);
    extra = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("t5_no_done", 32'(extra), 32'd0);
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    waitResult("t5b", N);
    @(negedge clk);

    $display("[TB] start accepted in DONE cycle");
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b1);
    waitResult("t6a", N);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
    checkOutput("t6_busy_after_restart", 32'(busy), 32'd1);
    checkOutput("t6_prev_sum_held", 32'(Sum), 32'h0003);
    waitResult("t6b", N);

    $display("[TB] random back-to-back");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      waitResult("rand", N);
    end
    @(negedge clk);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
